// File: rtl/uart_rx_fifo_if.sv
// MMU-side bus of the UART receive FIFO: pop/clear strobes in, head byte and status out.
// Handshake: q is meaningful only while valid=1; one byte is consumed on every CLK edge
// where re=1 and valid=1. re while valid=0 is ignored. clrErr is a one-cycle clear strobe.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          re;
  logic          clrErr;
  logic [7:0]    q;
  logic          valid;
  logic [CW-1:0] count;
  logic          overrun;
  logic          frameErr;

  modport master (
    output re, clrErr,
    input  q, valid, count, overrun, frameErr
  );

  modport slave (
    input  re, clrErr,
    output q, valid, count, overrun, frameErr
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a first-word-fall-through FIFO, with sticky overrun and
// framing-error flags. dbg_state exposes the receiver FSM: 0 IDLE, 1 START, 2 DATA, 3 STOP, 4 BREAK.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           rxPin,
  uart_rx_fifo_if.slave  bus,
  output logic [2:0]     dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // ---------------------------------------------------------------- synchronizer
  logic sync1;
  logic rxS;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= 1'b1;
      rxS   <= 1'b1;
    end else begin
      sync1 <= rxPin;
      rxS   <= sync1;
    end
  end

  // ---------------------------------------------------------------- receiver FSM
  state_t        state;
  logic [TW-1:0] tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick_zero;
  logic          push;
  logic          frame_bad;

  assign tick_zero = (tick == '0);
  // The stop-bit sample edge is also the FIFO write edge, so these decode the current state.
  assign push      = (state == S_STOP) && tick_zero && rxS;
  assign frame_bad = (state == S_STOP) && tick_zero && !rxS;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      tick    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxS) begin
            state <= S_START;
            tick  <= TICK_HALF;
          end
        end
        S_START: begin
          if (tick_zero) begin
            if (!rxS) begin
              state   <= S_DATA;
              bit_idx <= '0;
              tick    <= TICK_FULL;
            end else begin
              state <= S_IDLE;
              tick  <= '0;
            end
          end else begin
            tick <= tick - 1'b1;
          end
        end
        S_DATA: begin
          if (tick_zero) begin
            shreg <= {rxS, shreg[7:1]};
            tick  <= TICK_FULL;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            tick <= tick - 1'b1;
          end
        end
        S_STOP: begin
          if (tick_zero) begin
            state <= rxS ? S_IDLE : S_BREAK;
            tick  <= '0;
          end else begin
            tick <= tick - 1'b1;
          end
        end
        S_BREAK: begin
          // A line held low after a bad stop bit must not look like a fresh start bit.
          if (rxS) begin
            state <= S_IDLE;
            tick  <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          tick  <= '0;
        end
      endcase
    end
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          pop;
  logic          full;
  logic          do_write;

  assign pop      = bus.re && (cnt != '0);
  assign full     = (cnt == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_write = push && (!full || pop);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_write, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------- error flags
  logic overrun_r;
  logic frame_err_r;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (push && full && !pop) begin
        overrun_r <= 1'b1;
      end else if (bus.clrErr) begin
        overrun_r <= 1'b0;
      end
      if (frame_bad) begin
        frame_err_r <= 1'b1;
      end else if (bus.clrErr) begin
        frame_err_r <= 1'b0;
      end
    end
  end

  assign bus.q        = mem[rd_ptr];
  assign bus.valid    = (cnt != '0);
  assign bus.count    = cnt;
  assign bus.overrun  = overrun_r;
  assign bus.frameErr = frame_err_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed 8N1 frames against a queue-level model of the receive FIFO.
module tb_uart_rx_fifo;
  localparam int C  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;
  // Falling edge driven just after edge e: two synchronizer edges, the edge that first sees
  // rxS low, half a bit to the start sample, then nine bit times to the stop sample.
  localparam int LAT = 3 + C / 2 + 9 * C;

  // ---------------------------------------------------------------- clock / reset
  logic       CLK   = 1'b0;
  logic       RST   = 1'b0;
  logic       rxPin = 1'b1;
  logic [2:0] dbg_state;
  int         cyc   = 0;

  always #5 CLK = ~CLK;

  uart_rx_fifo_if #(.DEPTH(D)) bus ();

  uart_rx_fifo #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rxPin     (rxPin),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard / model
  logic [7:0] exp_q[$];
  logic [7:0] push_at[int];
  bit         ferr_at[int];
  bit         m_ovr;
  bit         m_ferr;
  bit         m_set_ovr;
  int         vectors     = 0;
  int         miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (!RST) begin
      exp_q.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      if (bus.re && exp_q.size() != 0) void'(exp_q.pop_front());
      m_set_ovr = 1'b0;
      if (push_at.exists(cyc)) begin
        if (exp_q.size() < D) exp_q.push_back(push_at[cyc]);
        else m_set_ovr = 1'b1;
        push_at.delete(cyc);
      end
      if (bus.clrErr) begin
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
      end
      if (m_set_ovr) m_ovr = 1'b1;
      if (ferr_at.exists(cyc)) begin
        m_ferr = 1'b1;
        ferr_at.delete(cyc);
      end
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      check("valid", 32'(bus.valid), 32'(exp_q.size() != 0));
      check("count", 32'(bus.count), 32'(exp_q.size()));
      check("overrun", 32'(bus.overrun), 32'(m_ovr));
      check("frameErr", 32'(bus.frameErr), 32'(m_ferr));
      if (exp_q.size() != 0) check("q", 32'(bus.q), 32'(exp_q[0]));
    end
  end

  // ---------------------------------------------------------------- driver tasks
  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit sched);
    int e;
    e = cyc;
    if (sched) begin
      if (stop_ok) push_at[e + LAT] = b;
      else ferr_at[e + LAT] = 1'b1;
    end
    rxPin = 1'b0;
    idle(C);
    for (int k = 0; k < 8; k++) begin
      rxPin = b[k];
      idle(C);
    end
    rxPin = stop_ok;
    idle(C);
  endtask

  task automatic pop_one();
    bus.re = 1'b1;
    idle(1);
    bus.re = 1'b0;
  endtask

  task automatic clear_errors();
    bus.clrErr = 1'b1;
    idle(1);
    bus.clrErr = 1'b0;
  endtask

  // ---------------------------------------------------------------- directed sequence
  initial begin
    bus.re     = 1'b0;
    bus.clrErr = 1'b0;
    idle(3);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_q", 32'(bus.q), 'h00);
    check("rst_state", 32'(dbg_state), 0);
    RST = 1'b1;
    idle(5);

    // Single frame and its exact latency
    fork
      send_frame(8'h5A, 1'b1, 1'b1);
      begin
        idle(154);
        check("lat_valid_before", 32'(bus.valid), 0);
        idle(1);
        check("lat_valid_rise", 32'(bus.valid), 1);
        check("single_q", 32'(bus.q), 'h5A);
        check("single_count", 32'(bus.count), 1);
      end
    join
    pop_one();
    check("single_pop_valid", 32'(bus.valid), 0);
    check("single_pop_count", 32'(bus.count), 0);

    // Glitch rejection
    rxPin = 1'b0;
    idle(4);
    rxPin = 1'b1;
    check("glitch_in_start", 32'(dbg_state), 1);
    idle(30);
    check("glitch_state", 32'(dbg_state), 0);
    check("glitch_count", 32'(bus.count), 0);
    check("glitch_flags", 32'({bus.overrun, bus.frameErr}), 0);

    // Framing error, held-low line, then a good frame
    send_frame(8'h33, 1'b0, 1'b1);
    idle(40);
    rxPin = 1'b1;
    idle(10);
    check("ferr_flag", 32'(bus.frameErr), 1);
    check("ferr_count", 32'(bus.count), 0);
    check("ferr_state", 32'(dbg_state), 0);
    send_frame(8'h81, 1'b1, 1'b1);
    check("after_ferr_q", 32'(bus.q), 'h81);
    check("after_ferr_count", 32'(bus.count), 1);
    pop_one();
    clear_errors();
    check("ferr_cleared", 32'(bus.frameErr), 0);

    // Overflow and pointer wrap
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
    idle(2);
    check("ovf_count", 32'(bus.count), 4);
    check("ovf_flag", 32'(bus.overrun), 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_pop_q", 32'(bus.q), 32'(i));
      pop_one();
    end
    check("ovf_empty", 32'(bus.valid), 0);
    send_frame(8'h06, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    check("wrap_q6", 32'(bus.q), 'h06);
    pop_one();
    check("wrap_q7", 32'(bus.q), 'h07);
    pop_one();
    check("wrap_empty", 32'(bus.count), 0);
    clear_errors();
    check("ovr_cleared", 32'(bus.overrun), 0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1);
    check("full_count", 32'(bus.count), 4);
    fork
      send_frame(8'h14, 1'b1, 1'b1);
      begin
        idle(LAT - 1);
        bus.re = 1'b1;
        idle(1);
        bus.re = 1'b0;
        check("pp_count", 32'(bus.count), 4);
        check("pp_overrun", 32'(bus.overrun), 0);
      end
    join
    for (int i = 1; i <= 4; i++) begin
      check("pp_pop_q", 32'(bus.q), 32'('h10 + i));
      pop_one();
    end
    check("pp_empty", 32'(bus.count), 0);

    // Reset during data bit 3 of 0xA5, then a clean 0x3C
    send_frame(8'h99, 1'b1, 1'b1);
    check("pre_rst_count", 32'(bus.count), 1);
    rxPin = 1'b0;
    idle(C);
    for (int k = 0; k < 3; k++) begin
      rxPin = k[0] ? 1'b0 : 1'b1;
      idle(C);
    end
    rxPin = 1'b0;
    idle(6);
    RST = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.valid), 0);
    check("mid_rst_count", 32'(bus.count), 0);
    check("mid_rst_q", 32'(bus.q), 'h00);
    check("mid_rst_flags", 32'({bus.overrun, bus.frameErr}), 0);
    check("mid_rst_state", 32'(dbg_state), 0);
    rxPin = 1'b1;
    idle(1);
    RST = 1'b1;
    idle(40);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(5);
    check("post_rst_q", 32'(bus.q), 'h3C);
    check("post_rst_count", 32'(bus.count), 1);
    check("post_rst_flags", 32'({bus.overrun, bus.frameErr}), 0);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
